dm_subword_mem: RTL and testbench

//  Parametrised data memory for the MIPS datapath with byte/half/word load-store, sign/zero extension and a

---
 rtl/dm_subword_mem.sv | 178 +++++++++++++++++
 tb/tb_dm_subword_mem.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_subword_mem.sv
// dm_subword_mem: MIPS data memory with byte/half/word access, sign/zero extension, error flagging
// and a fixed-latency valid/ready port. Define DM_TRACE_EN to print every committed store.
module dm_subword_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int               ADDR_W     = $clog2(DEPTH_WORDS);
  localparam int               CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0]      ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_START  = CNT_W'(LATENCY - 1);
  localparam bit               LIVE       = (LATENCY == 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, commit;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic        c_we, c_uns, c_err;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata;
  logic [ADDR_W-1:0] c_idx;

  logic [31:0] cur_word, merged, load_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LIVE) begin
            commit = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_START;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state always uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are held for the multi-cycle case; with single-cycle latency the live fields commit.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign c_we    = LIVE ? req_we       : we_q;
  assign c_size  = LIVE ? req_size     : size_q;
  assign c_uns   = LIVE ? req_unsigned : uns_q;
  assign c_addr  = LIVE ? req_addr     : addr_q;
  assign c_wdata = LIVE ? req_wdata    : wdata_q;
  assign c_idx   = c_addr[ADDR_W+1:2];

  assign c_err = (c_size == 2'b11)
              || (c_size == 2'b01 && c_addr[0])
              || (c_size == 2'b10 && c_addr[1:0] != 2'b00)
              || (c_addr >= ADDR_LIMIT);

  assign cur_word = mem_q[c_idx];
  assign sel_byte = cur_word[{c_addr[1:0], 3'b000} +: 8];
  assign sel_half = cur_word[{c_addr[1], 4'b0000} +: 16];

  always_comb begin
    merged    = cur_word;
    load_data = cur_word;
    case (c_size)
      2'b00: begin
        merged[{c_addr[1:0], 3'b000} +: 8] = c_wdata[7:0];
        load_data = {{24{sel_byte[7] & ~c_uns}}, sel_byte};
      end
      2'b01: begin
        merged[{c_addr[1], 4'b0000} +: 16] = c_wdata[15:0];
        load_data = {{16{sel_half[15] & ~c_uns}}, sel_half};
      end
      2'b10:   merged = c_wdata;
      default: ;
    endcase
  end

`ifdef DM_TRACE_EN
  logic [31:0] pc_q, c_pc;
  always_ff @(posedge clk) begin
    if (accept) pc_q <= req_pc;
  end
  assign c_pc = LIVE ? req_pc : pc_q;
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  // NOTE: the whole array is reset because every word must read back as 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (commit && c_we && !c_err) begin
      mem_q[c_idx] <= merged;
`ifdef DM_TRACE_EN
      $display("@%h: *%h <= %h", c_pc, {c_addr[31:2], 2'b00}, merged);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= commit;
      if (commit) begin
        rsp_err_q   <= c_err;
        rsp_rdata_q <= (c_err || c_we) ? '0 : load_data;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_subword_mem.sv
// Self-checking bench for dm_subword_mem: one LATENCY=1 and one LATENCY=3 instance, directed
// steps followed by random traffic checked against a byte-array reference model.
module tb_dm_subword_mem;
  localparam int DEPTH1 = 1024;
  localparam int DEPTH3 = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, req_valid1, req_ready1, req_we1, req_unsigned1, rsp_valid1, rsp_err1;
  logic [1:0]  req_size1;
  logic [31:0] req_addr1, req_wdata1, req_pc1, rsp_rdata1;
  logic        reset3, req_valid3, req_ready3, req_we3, req_unsigned3, rsp_valid3, rsp_err3;
  logic [1:0]  req_size3;
  logic [31:0] req_addr3, req_wdata3, req_pc3, rsp_rdata3;

  dm_subword_mem #(.DEPTH_WORDS(DEPTH1), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_size(req_size1), .req_unsigned(req_unsigned1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .req_pc(req_pc1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  dm_subword_mem #(.DEPTH_WORDS(DEPTH3), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_size(req_size3), .req_unsigned(req_unsigned3), .req_addr(req_addr3), .req_wdata(req_wdata3),
    .req_pc(req_pc3), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  // Reference model: plain byte-addressed memories.
  logic [7:0] mem1 [DEPTH1*4];
  logic [7:0] mem3 [DEPTH3*4];

  int n_vectors     = 0;
  int n_miscompares = 0;
  int pc_count      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model(input bit l3);
    if (l3) for (int i = 0; i < DEPTH3*4; i++) mem3[i] = 8'h00;
    else    for (int i = 0; i < DEPTH1*4; i++) mem1[i] = 8'h00;
  endtask

  function automatic bit model_err(input int depth, input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)
        || (addr >= 32'(4 * depth));
  endfunction

  task automatic model_access(input bit l3, input bit we, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_rdata, output logic exp_err);
    int     nb;
    longint v;
    exp_err   = model_err(l3 ? DEPTH3 : DEPTH1, size, addr);
    exp_rdata = 32'h0;
    if (exp_err) return;
    nb = 1 << size;
    if (we) begin
      for (int i = 0; i < nb; i++) begin
        if (l3) mem3[addr + i] = wdata[8*i +: 8];
        else    mem1[addr + i] = wdata[8*i +: 8];
      end
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++)
        v += longint'(l3 ? mem3[addr + i] : mem1[addr + i]) << (8 * i);
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
      exp_rdata = v[31:0];
    end
  endtask

  task automatic drive(input bit l3, input bit v, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    pc_count++;
    if (l3) begin
      req_valid3 = v; req_we3 = we; req_size3 = size; req_unsigned3 = uns;
      req_addr3 = addr; req_wdata3 = wdata; req_pc3 = 32'h0040_0000 + 32'(4 * pc_count);
    end else begin
      req_valid1 = v; req_we1 = we; req_size1 = size; req_unsigned1 = uns;
      req_addr1 = addr; req_wdata1 = wdata; req_pc1 = 32'h0040_0000 + 32'(4 * pc_count);
    end
  endtask

  // One isolated request: waits for ready, checks ready/valid every cycle up to the response.
  task automatic xact(input string tag, input bit l3, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] obs_rdata, output logic obs_err);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          w;
    lat = l3 ? 3 : 1;
    @(negedge clk);
    drive(l3, 1'b1, we, size, uns, addr, wdata);
    w = 0;
    while (!(l3 ? req_ready3 : req_ready1) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "/ready_at_req"}, 32'(l3 ? req_ready3 : req_ready1), 32'd1);
    @(posedge clk);
    model_access(l3, we, size, uns, addr, wdata, exp_rdata, exp_err);
    #1;
    drive(l3, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    obs_rdata = 32'hDEAD_BEEF;
    obs_err   = 1'bx;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      check({tag, "/rsp_valid"}, 32'(l3 ? rsp_valid3 : rsp_valid1), 32'(n == lat));
      check({tag, "/ready"},     32'(l3 ? req_ready3 : req_ready1), 32'(n == lat));
    end
    obs_rdata = l3 ? rsp_rdata3 : rsp_rdata1;
    obs_err   = l3 ? rsp_err3   : rsp_err1;
    check({tag, "/rdata"}, obs_rdata, exp_rdata);
    check({tag, "/err"},   32'(obs_err), 32'(exp_err));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, e0, e1, e2;
    logic        er, ee;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    int          r;

    reset1 = 1'b1;
    reset3 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    clear_model(1'b0);
    clear_model(1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset1 = 1'b0;
    reset3 = 1'b0;

    check("reset/ready1", 32'(req_ready1), 32'd1);
    check("reset/valid1", 32'(rsp_valid1), 32'd0);
    check("reset/rdata1", rsp_rdata1, 32'h0);
    check("reset/err1",   32'(rsp_err1), 32'd0);
    check("reset/ready3", 32'(req_ready3), 32'd1);
    check("reset/valid3", 32'(rsp_valid3), 32'd0);
    check("reset/rdata3", rsp_rdata3, 32'h0);
    check("reset/err3",   32'(rsp_err3), 32'd0);

    // Word store / load.
    xact("t1_sw", 1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678, rd, er);
    xact("t1_lw", 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
    check("t1_lw_const", rd, 32'h1234_5678);

    // Byte store and signed/unsigned byte loads.
    xact("t2_sb",  1'b0, 1'b1, 2'd0, 1'b0, 32'h3, 32'h0000_00AB, rd, er);
    xact("t2_lw",  1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
    check("t2_lw_const", rd, 32'hAB34_5678);
    xact("t2_lb",  1'b0, 1'b0, 2'd0, 1'b0, 32'h3, 32'h0, rd, er);
    check("t2_lb_const", rd, 32'hFFFF_FFAB);
    xact("t2_lbu", 1'b0, 1'b0, 2'd0, 1'b1, 32'h3, 32'h0, rd, er);
    check("t2_lbu_const", rd, 32'h0000_00AB);

    // Half store on the upper half of word 1.
    xact("t3_sh",  1'b0, 1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_8001, rd, er);
    xact("t3_lh",  1'b0, 1'b0, 2'd1, 1'b0, 32'h6, 32'h0, rd, er);
    check("t3_lh_const", rd, 32'hFFFF_8001);
    xact("t3_lhu", 1'b0, 1'b0, 2'd1, 1'b1, 32'h6, 32'h0, rd, er);
    check("t3_lhu_const", rd, 32'h0000_8001);
    xact("t3_lw",  1'b0, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, er);
    check("t3_lw_const", rd, 32'h8001_0000);

    // Error cases: misaligned, illegal size, out of range; memory must be unchanged.
    xact("t4_lw2",   1'b0, 1'b0, 2'd2, 1'b0, 32'h2,    32'h0, rd, er);
    check("t4_lw2_err", 32'(er), 32'd1);
    xact("t4_sh1",   1'b0, 1'b1, 2'd1, 1'b0, 32'h1,    32'hFFFF_FFFF, rd, er);
    xact("t4_sz3",   1'b0, 1'b1, 2'd3, 1'b0, 32'h0,    32'hFFFF_FFFF, rd, er);
    check("t4_sz3_err", 32'(er), 32'd1);
    xact("t4_oor",   1'b0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'hFFFF_FFFF, rd, er);
    check("t4_oor_err", 32'(er), 32'd1);
    xact("t4_lw0",   1'b0, 1'b0, 2'd2, 1'b0, 32'h0,    32'h0, rd, er);
    check("t4_lw0_const", rd, 32'hAB34_5678);
    xact("t4_lw4",   1'b0, 1'b0, 2'd2, 1'b0, 32'h4,    32'h0, rd, er);
    check("t4_lw4_const", rd, 32'h8001_0000);

    // Last word in range.
    xact("t4_swtop", 1'b0, 1'b1, 2'd2, 1'b0, 32'hFFC, 32'hA5A5_0FF0, rd, er);
    xact("t4_lwtop", 1'b0, 1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, rd, er);
    check("t4_lwtop_const", rd, 32'hA5A5_0FF0);

    // LATENCY=1 back-to-back loads with valid held high.
    model_access(1'b0, 1'b0, 2'd2, 1'b0, 32'h0,   32'h0, e0, ee);
    model_access(1'b0, 1'b0, 2'd1, 1'b0, 32'h6,   32'h0, e1, ee);
    model_access(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, e2, ee);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("b2b/valid0", 32'(rsp_valid1), 32'd1);
    check("b2b/rdata0", rsp_rdata1, e0);
    check("b2b/ready0", 32'(req_ready1), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h6, 32'h0);
    @(negedge clk);
    check("b2b/valid1", 32'(rsp_valid1), 32'd1);
    check("b2b/rdata1", rsp_rdata1, e1);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0);
    @(negedge clk);
    check("b2b/valid2", 32'(rsp_valid1), 32'd1);
    check("b2b/rdata2", rsp_rdata1, e2);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("b2b/idle", 32'(rsp_valid1), 32'd0);

    // LATENCY=3 with valid held high: store then load, throughput 1/3.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D);
    check("t5/ready_T", 32'(req_ready3), 32'd1);
    @(posedge clk);
    model_access(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, e0, ee);
    #1;
    drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      check("t5/ready_busy", 32'(req_ready3), 32'd0);
      check("t5/valid_busy", 32'(rsp_valid3), 32'd0);
    end
    @(negedge clk);
    check("t5/ready_T3", 32'(req_ready3), 32'd1);
    check("t5/valid_T3", 32'(rsp_valid3), 32'd1);
    check("t5/rdata_T3", rsp_rdata3, 32'h0);
    @(posedge clk);
    model_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e1, ee);
    #1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      check("t5/ready_busy2", 32'(req_ready3), 32'd0);
      check("t5/valid_busy2", 32'(rsp_valid3), 32'd0);
    end
    @(negedge clk);
    check("t5/valid_T6", 32'(rsp_valid3), 32'd1);
    check("t5/rdata_T6", rsp_rdata3, e1);
    check("t5/rdata_T6_const", rsp_rdata3, 32'hCAFE_F00D);
    @(negedge clk);
    check("t5/valid_T7", 32'(rsp_valid3), 32'd0);
    check("t5/rdata_hold", rsp_rdata3, 32'hCAFE_F00D);

    // LATENCY=3 reset while a store is in flight.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h8, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset3 = 1'b1;
    @(negedge clk);
    reset3 = 1'b0;
    clear_model(1'b1);
    check("t6/ready_after_rst", 32'(req_ready3), 32'd1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t6/no_valid", 32'(rsp_valid3), 32'd0);
    end
    xact("t6_lw8", 1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, er);
    check("t6_lw8_const", rd, 32'h0);
    xact("t6_lw10", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    check("t6_lw10_const", rd, 32'h0);
    xact("t6_oor3", 1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, rd, er);
    check("t6_oor3_err", 32'(er), 32'd1);

    // Random traffic on both instances against the reference model.
    for (int k = 0; k < 160; k++) begin
      bit l3;
      l3 = (k % 3 == 2);
      r  = int'($urandom_range(0, 15));
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = l3 ? $urandom_range(1020, 1028) : $urandom_range(4092, 4100);
      else             addr = $urandom_range(0, 31);
      size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wdata = $urandom;
      xact("rand", l3, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, wdata, rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
